// File: rtl/pd_seq_ctrl.sv
// Power-domain sequencer for a power-gated datapath block: power-up settle, isolation release,
// drain of in-flight work, isolate, power-down, plus the isolated output clamp mux.
module pd_seq_ctrl #(
  parameter int             W           = 16,
  parameter int             SETTLE_CYC  = 4,
  parameter int             OFF_CYC     = 2,
  parameter int             DRAIN_MAX   = 64,
  parameter int             CLAMP_MODE  = 0,
  parameter logic [W-1:0]   CLAMP_CONST = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pwr_req,
  input  logic         start_in,
  input  logic         alu_busy,
  input  logic [W-1:0] alu_result,
  output logic         alu_pwr_en,
  output logic         iso_en,
  output logic         start_out,
  output logic [W-1:0] result,
  output logic [W-1:0] clamp_obs,
  output logic         pd_ready,
  output logic         drain_to,
  output logic [2:0]   state_obs
);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_PWR_UP = 3'd1;
  localparam logic [2:0] S_ON     = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_ISO    = 3'd4;
  localparam logic [2:0] S_PWR_DN = 3'd5;

  // One shared down-counter sized for the longest of the three timed phases.
  localparam int CMAX_A = (SETTLE_CYC > OFF_CYC) ? SETTLE_CYC : OFF_CYC;
  localparam int CMAX   = (DRAIN_MAX > CMAX_A) ? DRAIN_MAX : CMAX_A;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] OFF_LD    = CW'(OFF_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_MAX - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [2:0]    state_r;
  logic [2:0]    state_nx_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx_s;
  logic          timeout_s;
  logic          pwr_en_nx_s;
  logic          iso_nx_s;
  logic          alu_pwr_en_r;
  logic          iso_en_r;
  logic          drain_to_r;
  logic [W-1:0]  hold_r;
  logic [W-1:0]  clamp_s;

  function automatic logic [W-1:0] clamp_fn(input logic [W-1:0] hold);
    logic [W-1:0] v;
    case (CLAMP_MODE)
      32'sd0:  v = {W{1'b0}};
      32'sd1:  v = {W{1'b1}};
      32'sd2:  v = hold;
      32'sd3:  v = CLAMP_CONST;
      default: v = {W{1'b0}};
    endcase
    return v;
  endfunction

  // Next-state and counter decode; priority in DRAIN is request, then busy, then timeout.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    timeout_s  = 1'b0;
    case (state_r)
      S_OFF: begin
        if (pwr_req) begin
          state_nx_s = S_PWR_UP;
          cnt_nx_s   = SETTLE_LD;
        end else begin
          state_nx_s = S_OFF;
        end
      end
      S_PWR_UP: begin
        if (!pwr_req) begin
          state_nx_s = S_PWR_DN;
          cnt_nx_s   = OFF_LD;
        end else if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_ON;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_ON: begin
        if (pwr_req) begin
          state_nx_s = S_ON;
        end else if (alu_busy) begin
          state_nx_s = S_DRAIN;
          cnt_nx_s   = DRAIN_LD;
        end else begin
          state_nx_s = S_ISO;
        end
      end
      S_DRAIN: begin
        if (pwr_req) begin
          state_nx_s = S_ON;
          cnt_nx_s   = CNT_ZERO;
        end else if (!alu_busy) begin
          state_nx_s = S_ISO;
        end else if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_ISO;
          timeout_s  = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_ISO: begin
        state_nx_s = S_PWR_DN;
        cnt_nx_s   = OFF_LD;
      end
      S_PWR_DN: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_OFF;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx_s = S_OFF;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Power and isolation controls decoded from the next state so they change with the state flop.
  always_comb begin
    pwr_en_nx_s = 1'b0;
    iso_nx_s    = 1'b1;
    case (state_nx_s)
      S_PWR_UP: begin pwr_en_nx_s = 1'b1; iso_nx_s = 1'b1; end
      S_ON:     begin pwr_en_nx_s = 1'b1; iso_nx_s = 1'b0; end
      S_DRAIN:  begin pwr_en_nx_s = 1'b1; iso_nx_s = 1'b0; end
      S_ISO:    begin pwr_en_nx_s = 1'b1; iso_nx_s = 1'b1; end
      default:  begin pwr_en_nx_s = 1'b0; iso_nx_s = 1'b1; end
    endcase
  end

  // State, counter and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_OFF;
      cnt_r        <= CNT_ZERO;
      alu_pwr_en_r <= 1'b0;
      iso_en_r     <= 1'b1;
      drain_to_r   <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      alu_pwr_en_r <= pwr_en_nx_s;
      iso_en_r     <= iso_nx_s;
      drain_to_r   <= timeout_s;
    end
  end

  // Hold register tracks the result while unisolated and freezes once isolation is on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= {W{1'b0}};
    end else if (!iso_en_r) begin
      hold_r <= alu_result;
    end else begin
      hold_r <= hold_r;
    end
  end

  assign clamp_s    = clamp_fn(hold_r);
  assign alu_pwr_en = alu_pwr_en_r;
  assign iso_en     = iso_en_r;
  assign drain_to   = drain_to_r;
  assign state_obs  = state_r;
  assign pd_ready   = (state_r == S_ON);
  assign start_out  = start_in & (state_r == S_ON);
  assign clamp_obs  = clamp_s;
  assign result     = iso_en_r ? clamp_s : alu_result;

endmodule

// File: tb/tb_pd_seq_ctrl.sv
// Scoreboard bench for pd_seq_ctrl: directed stimulus pushes expected post-edge outputs,
// a negedge monitor pops and compares them (hold-mode DUT plus an all-ones clamp DUT).
module tb_pd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_req = 1'b0;
  logic        start_in = 1'b0;
  logic        alu_busy = 1'b0;
  logic [15:0] alu_result = 16'h0000;

  logic        alu_pwr_en, iso_en, start_out, pd_ready, drain_to;
  logic [15:0] result, clamp_obs;
  logic [2:0]  state_obs;
  logic        alu_pwr_en1, iso_en1, start_out1, pd_ready1, drain_to1;
  logic [15:0] result1, clamp_obs1;
  logic [2:0]  state_obs1;

  typedef struct packed {
    logic [95:0] nm;
    int          tgt;
    logic [2:0]  st;
    logic        pe;
    logic        iso;
    logic        so;
    logic        dt;
    logic [15:0] res;
    logic [15:0] res1;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pd_seq_ctrl #(.W(16), .SETTLE_CYC(4), .OFF_CYC(2), .DRAIN_MAX(64),
                .CLAMP_MODE(2), .CLAMP_CONST(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .start_in(start_in),
    .alu_busy(alu_busy), .alu_result(alu_result), .alu_pwr_en(alu_pwr_en),
    .iso_en(iso_en), .start_out(start_out), .result(result), .clamp_obs(clamp_obs),
    .pd_ready(pd_ready), .drain_to(drain_to), .state_obs(state_obs)
  );

  pd_seq_ctrl #(.W(16), .SETTLE_CYC(4), .OFF_CYC(2), .DRAIN_MAX(64),
                .CLAMP_MODE(1), .CLAMP_CONST(16'h0000)) dut1 (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .start_in(start_in),
    .alu_busy(alu_busy), .alu_result(alu_result), .alu_pwr_en(alu_pwr_en1),
    .iso_en(iso_en1), .start_out(start_out1), .result(result1), .clamp_obs(clamp_obs1),
    .pd_ready(pd_ready1), .drain_to(drain_to1), .state_obs(state_obs1)
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every expectation whose target edge has been reached.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tgt <= edge_cnt) begin
      mon_e = q.pop_front();
      checks = checks + 1;
      if (mon_e.tgt != edge_cnt || state_obs !== mon_e.st || alu_pwr_en !== mon_e.pe ||
          iso_en !== mon_e.iso || start_out !== mon_e.so || drain_to !== mon_e.dt ||
          pd_ready !== (mon_e.st == 3'd2) || result !== mon_e.res ||
          result1 !== mon_e.res1 || clamp_obs1 !== 16'hFFFF) begin
        failures = failures + 1;
        $display("FAIL %0s: got st=%0d pe=%b iso=%b so=%b dt=%b rdy=%b res=%h res1=%h clamp1=%h; exp st=%0d pe=%b iso=%b so=%b dt=%b res=%h res1=%h clamp1=ffff (edge %0d/%0d)",
                 mon_e.nm, state_obs, alu_pwr_en, iso_en, start_out, drain_to, pd_ready,
                 result, result1, clamp_obs1, mon_e.st, mon_e.pe, mon_e.iso, mon_e.so,
                 mon_e.dt, mon_e.res, mon_e.res1, edge_cnt, mon_e.tgt);
      end
    end
  end

  function automatic exp_t mk(input logic [95:0] nm, input int tgt, input logic [2:0] st,
                              input logic pe, input logic iso, input logic so,
                              input logic dt, input logic [15:0] er, input logic [15:0] r);
    exp_t e;
    e.nm = nm; e.tgt = tgt; e.st = st; e.pe = pe; e.iso = iso; e.so = so; e.dt = dt;
    e.res = er;
    e.res1 = iso ? 16'hFFFF : r;
    return e;
  endfunction

  // One clock cycle: apply inputs, optionally expect outputs after the next edge.
  task automatic cyc(input logic p, input logic s, input logic b, input logic [15:0] r,
                     input logic chk, input logic [95:0] nm, input logic [2:0] st,
                     input logic pe, input logic iso, input logic so, input logic dt,
                     input logic [15:0] er);
    @(negedge clk);
    #1;
    pwr_req = p; start_in = s; alu_busy = b; alu_result = r;
    if (chk) q.push_back(mk(nm, edge_cnt + 1, st, pe, iso, so, dt, er, r));
  endtask

  // Assert reset just after an edge and expect reset values before the next edge.
  task automatic do_reset(input logic [15:0] r);
    @(posedge clk);
    #2;
    rst_n = 1'b0; alu_result = r;
    q.push_back(mk("reset", edge_cnt, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, r));
    @(negedge clk);
    #1;
    pwr_req = 1'b0; alu_busy = 1'b0; start_in = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic power_up(input logic [15:0] r, input logic [15:0] hold);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 1'b0, r, 1'b1, "pwrup", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, hold);
    cyc(1'b1, 1'b1, 1'b0, r, 1'b1, "on", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, r);
  endtask

  initial begin
    do_reset(16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, "idle_off", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Power up, then isolate from ON with no work in flight; hold keeps BEEF.
    power_up(16'h1234, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b1, "on_beef", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    cyc(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1, "iso", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "pwrdn1", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "pwrdn2", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "off_hold", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF);

    // Drain with busy for 10 cycles, start blocked, then normal isolation.
    power_up(16'h5555, 16'hBEEF);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, "drain", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555);
    cyc(1'b0, 1'b1, 1'b0, 16'h6666, 1'b1, "drain_iso", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'h6666);
    cyc(1'b1, 1'b0, 1'b0, 16'h6666, 1'b1, "dn_ignore1", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h6666);
    cyc(1'b1, 1'b0, 1'b0, 16'h6666, 1'b1, "dn_ignore2", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h6666);
    cyc(1'b1, 1'b0, 1'b0, 16'h6666, 1'b1, "off_pend", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h6666);

    // Busy stuck high: exactly 64 DRAIN cycles, then forced ISO with a one-cycle drain_to.
    power_up(16'h7777, 16'h6666);
    for (int i = 0; i < 64; i++)
      cyc(1'b0, 1'b0, 1'b1, 16'h7777, (i == 0 || i == 63), "drain_to", 3'd3, 1'b1, 1'b0,
          1'b0, 1'b0, 16'h7777);
    cyc(1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, "to_iso", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 16'h7777);
    cyc(1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, "to_clear", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(1'b0, 1'b0, 1'b0, 16'h7777, 1'b1, "to_dn2", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(1'b0, 1'b0, 1'b0, 16'h7777, 1'b1, "to_off", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);

    // Request withdrawn during PWR_UP: straight to PWR_DN, isolation never released.
    cyc(1'b1, 1'b0, 1'b0, 16'h2222, 1'b1, "ab_up1", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(1'b1, 1'b0, 1'b0, 16'h2222, 1'b1, "ab_up2", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, "ab_dn1", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, "ab_dn2", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, "ab_off", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);

    // Request returns during DRAIN: back to ON without isolating.
    power_up(16'h1111, 16'h7777);
    cyc(1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, "dr_enter", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111);
    cyc(1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, "dr_abort", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111);

    // Reset asserted mid-DRAIN must take effect before the next clock edge.
    cyc(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, "", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_reset(16'h9999);
    cyc(1'b0, 1'b0, 1'b0, 16'h9999, 1'b1, "post_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      failures = failures + q.size();
      $display("FAIL drain_queue: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pd_seq_ctrl.md
Name: pd_seq_ctrl

Overview:
- Parametrised power-domain sequencer for a power-gated datapath block such as the ALU; next generation of the plain clamp/isolation output mux.
- Replaces directly driven alu_pwr_en/iso_en with a request-driven sequence: power-up settle, isolation release, drain of in-flight work, isolate, power-down.
- Owns the isolated output mux, with selectable clamp modes including hold-last-value.
- Sits between the power-management request source and the gated block.

Parameters:
W, 16, datapath/result width
SETTLE_CYC, 4, cycles in PWR_UP before isolation release (>=1)
OFF_CYC, 2, cycles in PWR_DN before OFF (>=1)
DRAIN_MAX, 64, max cycles waiting for busy to drop before forced isolation (>=1)
CLAMP_MODE, 0, 0=zeros, 1=all ones, 2=hold last unisolated result, 3=CLAMP_CONST
CLAMP_CONST, 0, W-bit clamp value used when CLAMP_MODE=3

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pwr_req  in  1  1=domain wanted on, 0=wanted off
start_in  in  1  start request from upstream
alu_busy  in  1  gated block has work in flight (ignored while alu_pwr_en=0)
alu_result  in  W  gated block result
alu_pwr_en  out  1  registered power enable to gated block
iso_en  out  1  registered isolation enable
start_out  out  1  start_in gated: start_in & (state==ON)
result  out  W  iso_en ? clamp_value : alu_result (combinational)
clamp_obs  out  W  current clamp_value
pd_ready  out  1  state==ON
drain_to  out  1  one-cycle registered pulse on forced isolation after drain timeout
state_obs  out  3  encoded state: OFF=0, PWR_UP=1, ON=2, DRAIN=3, ISO=4, PWR_DN=5

Behaviour:
- One clock domain; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=OFF, alu_pwr_en=0, iso_en=1, drain_to=0, hold register=0, counters=0.
  - result=clamp_value during reset (hold mode gives 0).
- alu_pwr_en and iso_en are flops updated on the same edge as the state register, never decoded combinationally.
  - alu_pwr_en=1 in PWR_UP, ON, DRAIN, ISO.
  - iso_en=0 only in ON and DRAIN.
- OFF:
  - pwr_req=1 -> PWR_UP, counter loaded SETTLE_CYC-1.
- PWR_UP (power on, isolated):
  - Stays exactly SETTLE_CYC cycles, then -> ON if pwr_req=1.
  - pwr_req=0 at any cycle of PWR_UP -> PWR_DN immediately; ISO is skipped because isolation is already on.
- ON:
  - pwr_req=0 & alu_busy=0 -> ISO.
  - pwr_req=0 & alu_busy=1 -> DRAIN, counter loaded DRAIN_MAX-1.
- DRAIN (power on, not isolated, start_out blocked):
  - pwr_req=1 -> ON; abort power-down, counter discarded.
  - Else alu_busy=0 -> ISO.
  - Else counter==0 -> ISO with drain_to=1 for exactly the cycle ISO is active.
  - Priority: pwr_req, then busy, then timeout.
- ISO: exactly 1 cycle with iso_en=1 and alu_pwr_en=1 (isolate-before-power-off); then -> PWR_DN, counter loaded OFF_CYC-1.
- PWR_DN:
  - alu_pwr_en=0, iso_en=1, exactly OFF_CYC cycles, then -> OFF.
  - pwr_req ignored; a pending pwr_req=1 is seen in OFF the following cycle.
- Clamp value:
  - Mode 0 = 0; mode 1 = all ones; mode 3 = CLAMP_CONST.
  - Mode 2: hold register captures alu_result on every edge where iso_en=0. It is frozen while iso_en=1, so it holds the last result presented before isolation asserted.
- start_out is forced 0 outside ON, including DRAIN, so no new operation launches during power-down.
- Reset asserted in any state: outputs return asynchronously to reset values. Mid-operation results are lost; the hold register clears to 0.
- Invalid state encodings -> OFF.

Test Plan:
- Reset, then pwr_req=1 at edge 0 (SETTLE_CYC=4) -> alu_pwr_en=1 after edge 1; iso_en=0 and pd_ready=1 after edge 5; result tracks alu_result (e.g. 16'h1234).
- In ON, CLAMP_MODE=2, alu_result=16'hBEEF, pwr_req=0, busy=0 -> ISO one cycle, result=16'hBEEF stays through PWR_DN (2 cycles) and OFF while alu_result goes to 16'hXXXX/0; alu_pwr_en falls one cycle after iso_en rises.
- pwr_req=0 with busy=1 for 10 cycles -> DRAIN 10 cycles, start_out=0 despite start_in=1, then ISO with drain_to=0.
- busy stuck 1, DRAIN_MAX=64 -> ISO after exactly 64 DRAIN cycles, drain_to=1 for one cycle.
- pwr_req drops on cycle 2 of PWR_UP -> PWR_DN next cycle, iso_en never deasserts. Separately, pwr_req returns to 1 during DRAIN -> back to ON, iso_en stays 0.
- rst_n asserted mid-DRAIN -> immediately alu_pwr_en=0, iso_en=1, state_obs=0, result=clamp (0 in modes 0/2, 16'hFFFF in mode 1).
